// File: rtl/uart_tx_rx_buff_baud3.sv
// UART receiver with an 'S',<ch>,<value> command parser driving four trigger-level registers.
// Define UART_ECHO_EN to add a 4-entry FIFO and 8N1 transmitter that echoes every good byte.
module uart_tx_rx_buff_baud3 #(
    parameter int CLK_HZ   = 12000000,
    parameter int DIV_9600 = 1250,
    parameter int DIV_2400 = 5000,
    parameter int DIV_600  = 20000,
    parameter int DIV_110  = 109091
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [1:0] baud,
    input  logic       rx,
    output logic       tx,
    output logic       rx2,
    output logic       tx2,
    output logic [7:0] trigout_ch0,
    output logic [7:0] trigout_ch1,
    output logic [7:0] trigout_ch2,
    output logic [7:0] trigout_ch3,
    output logic       busy,
    output logic       trig_en,
    output logic [2:0] vt_ind,
    output logic [4:0] byte_count
);
    // Counter must hold the slowest divisor, whether given explicitly or derived from the clock.
    localparam int DIV_MAX = (DIV_110 > CLK_HZ / 110) ? DIV_110 : CLK_HZ / 110;
    localparam int CNT_W   = $clog2(DIV_MAX + 1);

    logic [CNT_W-1:0] div_sel;

    always_comb begin
        unique case (baud)
            2'b11: div_sel = CNT_W'(DIV_9600);
            2'b10: div_sel = CNT_W'(DIV_2400);
            2'b01: div_sel = CNT_W'(DIV_600);
            2'b00: div_sel = CNT_W'(DIV_110);
        endcase
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    rx_state_t rx_state, rx_next;

    logic             rx_s1, rx_s2;
    logic [CNT_W-1:0] rx_div, rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             rx_err, rx_valid;
    logic             rx_tick, rx_half, rx_good, rx_bad;

    assign rx_tick = (rx_cnt == rx_div - 1'b1);
    assign rx_half = (rx_cnt == (rx_div >> 1) - 1'b1);
    assign rx_good = (rx_state == STOP) && !rx_err && rx_tick && rx_s2;
    assign rx_bad  = (rx_state == STOP) && !rx_err && rx_tick && !rx_s2;
    assign rx2     = rx_s2;

    always_comb begin
        rx_next = rx_state;
        unique case (rx_state)
            IDLE:  if (!rx_s2) rx_next = START;
            START: if (rx_half) rx_next = rx_s2 ? IDLE : DATA;
            DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = STOP;
            // After a framing error, hold here until the line returns to idle.
            STOP:  if (rx_err ? rx_s2 : rx_good) rx_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_state   <= IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_err     <= 1'b0;
            rx_valid   <= 1'b0;
            byte_count <= '0;
        end else begin
            rx_s1    <= rx;
            rx_s2    <= rx_s1;
            rx_state <= rx_next;
            rx_valid <= rx_good;
            if (rx_good) byte_count <= byte_count + 1'b1;
            unique case (rx_state)
                IDLE: begin
                    rx_cnt <= '0;
                    rx_bit <= '0;
                    rx_err <= 1'b0;
                end
                START: rx_cnt <= rx_half ? '0 : rx_cnt + 1'b1;
                DATA: begin
                    rx_cnt <= rx_tick ? '0 : rx_cnt + 1'b1;
                    if (rx_tick) rx_bit <= rx_bit + 1'b1;
                end
                STOP: begin
                    rx_cnt <= rx_tick ? '0 : rx_cnt + 1'b1;
                    if (rx_bad) rx_err <= 1'b1;
                end
            endcase
        end
    end

    // Divisor is captured only while idle so a baud change never corrupts a frame in flight.
    always_ff @(posedge clk) begin
        if (rx_state == IDLE) rx_div <= div_sel;
        if (rx_state == DATA && rx_tick) rx_shift <= {rx_s2, rx_shift[7:1]};
    end

    typedef enum logic [1:0] {P_IDLE, P_CH, P_VAL} p_state_t;
    p_state_t p_state, p_next;
    logic [1:0] ch;

    always_comb begin
        p_next = p_state;
        if (rx_valid) begin
            unique case (p_state)
                P_IDLE:  if (rx_shift == 8'h53) p_next = P_CH;
                P_CH:    p_next = (rx_shift[7:2] == 6'b001100) ? P_VAL : P_IDLE;
                P_VAL:   p_next = P_IDLE;
                default: p_next = P_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            p_state     <= P_IDLE;
            ch          <= '0;
            trig_en     <= 1'b0;
            vt_ind      <= '0;
            trigout_ch0 <= '0;
            trigout_ch1 <= '0;
            trigout_ch2 <= '0;
            trigout_ch3 <= '0;
        end else begin
            p_state <= p_next;
            trig_en <= 1'b0;
            if (rx_valid && p_state == P_CH) ch <= rx_shift[1:0];
            if (rx_valid && p_state == P_VAL) begin
                trig_en <= 1'b1;
                vt_ind  <= {1'b1, ch};
                unique case (ch)
                    2'd0: trigout_ch0 <= rx_shift;
                    2'd1: trigout_ch1 <= rx_shift;
                    2'd2: trigout_ch2 <= rx_shift;
                    2'd3: trigout_ch3 <= rx_shift;
                endcase
            end
        end
    end

`ifdef UART_ECHO_EN
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
    tx_state_t tx_state, tx_next;

    logic [7:0]       fifo_mem [4];
    logic [1:0]       wr_ptr, rd_ptr;
    logic [2:0]       fifo_cnt;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0] tx_div, tx_cnt;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_shift;
    logic             tx_tick;

    assign fifo_full  = (fifo_cnt == 3'd4);
    assign fifo_empty = (fifo_cnt == 3'd0);
    assign fifo_pop   = (tx_state == T_IDLE) && !fifo_empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign fifo_push  = rx_valid && (!fifo_full || fifo_pop);
    assign tx_tick    = (tx_cnt == tx_div - 1'b1);

    always_comb begin
        tx_next = tx_state;
        unique case (tx_state)
            T_IDLE:  if (!fifo_empty) tx_next = T_START;
            T_START: if (tx_tick) tx_next = T_DATA;
            T_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = T_STOP;
            T_STOP:  if (tx_tick) tx_next = T_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            tx_state <= T_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            tx_cnt   <= '0;
            tx_bit   <= '0;
        end else begin
            tx_state <= tx_next;
            if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt <= fifo_cnt + {2'b00, fifo_push} - {2'b00, fifo_pop};
            tx_cnt   <= (tx_state == T_IDLE || tx_tick) ? '0 : tx_cnt + 1'b1;
            if (tx_state == T_IDLE) tx_bit <= '0;
            else if (tx_state == T_DATA && tx_tick) tx_bit <= tx_bit + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr] <= rx_shift;
        if (fifo_pop) begin
            tx_shift <= fifo_mem[rd_ptr];
            tx_div   <= div_sel;
        end else if (tx_state == T_DATA && tx_tick) begin
            tx_shift <= {1'b1, tx_shift[7:1]};
        end
    end

    assign tx   = (tx_state == T_START) ? 1'b0 : (tx_state == T_DATA) ? tx_shift[0] : 1'b1;
    assign busy = (rx_state != IDLE) || (tx_state != T_IDLE) || !fifo_empty;
`else
    assign tx   = 1'b1;
    assign busy = (rx_state != IDLE);
`endif

    assign tx2 = tx;
endmodule

// File: tb/tb_uart_tx_rx_buff_baud3.sv
// Directed bench for uart_tx_rx_buff_baud3: command parsing, framing, glitch rejection, baud select.
// Divisors are scaled down so every frame stays short; bit timing is driven in whole clocks.
`timescale 1ns/1ps
module tb_uart_tx_rx_buff_baud3;
    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       rx = 1'b1;
    logic [1:0] baud = 2'b11;
    logic       tx, rx2, tx2, busy, trig_en;
    logic [7:0] trigout_ch0, trigout_ch1, trigout_ch2, trigout_ch3;
    logic [2:0] vt_ind;
    logic [4:0] byte_count;

    int n_cmp = 0;
    int n_fail = 0;
    int trig_cnt = 0;
    int tx_bad = 0;
    bit mon_on = 1'b0;

    localparam int B11 = 100;
    localparam int B10 = 130;
    localparam int B01 = 170;
    localparam int B00 = 210;

    uart_tx_rx_buff_baud3 #(
        .DIV_9600(B11), .DIV_2400(B10), .DIV_600(B01), .DIV_110(B00)
    ) dut (
        .clk(clk), .nrst(nrst), .baud(baud), .rx(rx), .tx(tx), .rx2(rx2), .tx2(tx2),
        .trigout_ch0(trigout_ch0), .trigout_ch1(trigout_ch1),
        .trigout_ch2(trigout_ch2), .trigout_ch3(trigout_ch3),
        .busy(busy), .trig_en(trig_en), .vt_ind(vt_ind), .byte_count(byte_count)
    );

    always #41.667 clk = ~clk;

    always @(negedge clk) begin
        if (trig_en === 1'b1) trig_cnt <= trig_cnt + 1;
        if (mon_on && (tx !== 1'b1 || tx2 !== 1'b1)) tx_bad <= tx_bad + 1;
    end

    task automatic send_byte(input logic [7:0] b, input int bclk, input logic stop_v, input int gap,
                             input int chg_bit = -1, input logic [1:0] chg_baud = 2'b00);
        rx = 1'b0;
        repeat (bclk) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (i == chg_bit) baud = chg_baud;
            rx = b[i];
            repeat (bclk) @(negedge clk);
        end
        rx = stop_v;
        repeat (bclk) @(negedge clk);
        rx = 1'b1;
        repeat (gap * bclk) @(negedge clk);
    endtask

    task automatic test_reset();
        nrst = 1'b0; rx = 1'b1; baud = 2'b11;
        repeat (3) @(negedge clk);
        n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_cmp++; if (rx2 !== 1'b1 || tx2 !== 1'b1) begin n_fail++; $display("FAIL reset_mirrors: got rx2=%b tx2=%b want 1/1", rx2, tx2); end
        n_cmp++; if ({trigout_ch0, trigout_ch1, trigout_ch2, trigout_ch3} !== 32'h0) begin n_fail++; $display("FAIL reset_trigout: got %h want 0", {trigout_ch0, trigout_ch1, trigout_ch2, trigout_ch3}); end
        n_cmp++; if (byte_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", byte_count); end
        n_cmp++; if (vt_ind !== 3'b000 || trig_en !== 1'b0) begin n_fail++; $display("FAIL reset_vt: got vt=%b en=%b want 000/0", vt_ind, trig_en); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        nrst = 1'b1;
        mon_on = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_trigger_ch0();
        send_byte(8'h53, B11, 1'b1, 1);
        send_byte(8'h30, B11, 1'b1, 1);
        send_byte(8'hAB, B11, 1'b1, 1);
        n_cmp++; if (trigout_ch0 !== 8'hAB) begin n_fail++; $display("FAIL ch0_value: got %h want ab", trigout_ch0); end
        n_cmp++; if (trig_cnt !== 1) begin n_fail++; $display("FAIL ch0_trig_pulses: got %0d want 1", trig_cnt); end
        n_cmp++; if (vt_ind !== 3'b100) begin n_fail++; $display("FAIL ch0_vt: got %b want 100", vt_ind); end
        n_cmp++; if (byte_count !== 5'd3) begin n_fail++; $display("FAIL ch0_count: got %0d want 3", byte_count); end
        n_cmp++; if ({trigout_ch1, trigout_ch2, trigout_ch3} !== 24'h0) begin n_fail++; $display("FAIL ch0_others: got %h want 0", {trigout_ch1, trigout_ch2, trigout_ch3}); end
    endtask

    task automatic test_trigger_ch3();
        send_byte(8'h53, B11, 1'b1, 10);
        send_byte(8'h33, B11, 1'b1, 10);
        send_byte(8'h5A, B11, 1'b1, 10);
        n_cmp++; if (trigout_ch3 !== 8'h5A) begin n_fail++; $display("FAIL ch3_value: got %h want 5a", trigout_ch3); end
        n_cmp++; if (vt_ind !== 3'b111) begin n_fail++; $display("FAIL ch3_vt: got %b want 111", vt_ind); end
        n_cmp++; if (byte_count !== 5'd6) begin n_fail++; $display("FAIL ch3_count: got %0d want 6", byte_count); end
        n_cmp++; if (trigout_ch0 !== 8'hAB || trig_cnt !== 2) begin n_fail++; $display("FAIL ch3_retain: got ch0=%h pulses=%0d want ab/2", trigout_ch0, trig_cnt); end
    endtask

    task automatic test_bad_channel();
        send_byte(8'h53, B11, 1'b1, 1);
        send_byte(8'h39, B11, 1'b1, 1);
        send_byte(8'h11, B11, 1'b1, 1);
        n_cmp++; if (trig_cnt !== 2 || trigout_ch1 !== 8'h00) begin n_fail++; $display("FAIL badch_nowrite: got pulses=%0d ch1=%h want 2/00", trig_cnt, trigout_ch1); end
        n_cmp++; if (byte_count !== 5'd9) begin n_fail++; $display("FAIL badch_count: got %0d want 9", byte_count); end
        send_byte(8'h53, B11, 1'b1, 1);
        send_byte(8'h31, B11, 1'b1, 1);
        send_byte(8'h22, B11, 1'b1, 1);
        n_cmp++; if (trigout_ch1 !== 8'h22) begin n_fail++; $display("FAIL ch1_value: got %h want 22", trigout_ch1); end
        n_cmp++; if (vt_ind !== 3'b101 || trig_cnt !== 3) begin n_fail++; $display("FAIL ch1_vt: got vt=%b pulses=%0d want 101/3", vt_ind, trig_cnt); end
    endtask

    task automatic test_framing_error();
        send_byte(8'h53, B11, 1'b1, 1);
        send_byte(8'h30, B11, 1'b0, 2);
        n_cmp++; if (byte_count !== 5'd13) begin n_fail++; $display("FAIL frame_count: got %0d want 13", byte_count); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL frame_recover: got busy=%b want 0", busy); end
        send_byte(8'h32, B11, 1'b1, 1);
        send_byte(8'h77, B11, 1'b1, 1);
        n_cmp++; if (trigout_ch2 !== 8'h77 || vt_ind !== 3'b110) begin n_fail++; $display("FAIL frame_parser: got ch2=%h vt=%b want 77/110", trigout_ch2, vt_ind); end
        n_cmp++; if (byte_count !== 5'd15 || trigout_ch0 !== 8'hAB) begin n_fail++; $display("FAIL frame_after: got count=%0d ch0=%h want 15/ab", byte_count, trigout_ch0); end
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++; if (busy !== 1'b1 || rx2 !== 1'b0) begin n_fail++; $display("FAIL glitch_start: got busy=%b rx2=%b want 1/0", busy, rx2); end
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || byte_count !== 5'd15) begin n_fail++; $display("FAIL glitch_reject: got busy=%b count=%0d want 0/15", busy, byte_count); end
    endtask

    task automatic test_tolerance();
        send_byte(8'h53, B11 - 2, 1'b1, 1);
        send_byte(8'h30, B11 - 2, 1'b1, 1);
        send_byte(8'hC3, B11 - 2, 1'b1, 1);
        n_cmp++; if (trigout_ch0 !== 8'hC3 || byte_count !== 5'd18) begin n_fail++; $display("FAIL fast_2pct: got ch0=%h count=%0d want c3/18", trigout_ch0, byte_count); end
        send_byte(8'h53, B11 + 2, 1'b1, 1);
        send_byte(8'h33, B11 + 2, 1'b1, 1);
        send_byte(8'h3C, B11 + 2, 1'b1, 1);
        n_cmp++; if (trigout_ch3 !== 8'h3C || byte_count !== 5'd21) begin n_fail++; $display("FAIL slow_2pct: got ch3=%h count=%0d want 3c/21", trigout_ch3, byte_count); end
    endtask

    task automatic test_baud_select();
        baud = 2'b10;
        send_byte(8'h53, B10, 1'b1, 1);
        send_byte(8'h31, B10, 1'b1, 1);
        send_byte(8'h96, B10, 1'b1, 1);
        n_cmp++; if (trigout_ch1 !== 8'h96 || byte_count !== 5'd24) begin n_fail++; $display("FAIL baud10: got ch1=%h count=%0d want 96/24", trigout_ch1, byte_count); end
        baud = 2'b01;
        send_byte(8'h53, B01, 1'b1, 1);
        send_byte(8'h32, B01, 1'b1, 1);
        send_byte(8'h4D, B01, 1'b1, 1);
        n_cmp++; if (trigout_ch2 !== 8'h4D || byte_count !== 5'd27) begin n_fail++; $display("FAIL baud01: got ch2=%h count=%0d want 4d/27", trigout_ch2, byte_count); end
        // Switch to baud 00 in the middle of a 9600-rate frame; only later frames use the new rate.
        baud = 2'b11;
        repeat (2) @(negedge clk);
        send_byte(8'h53, B11, 1'b1, 1, 2, 2'b00);
        send_byte(8'h30, B00, 1'b1, 1);
        send_byte(8'h0F, B00, 1'b1, 1);
        n_cmp++; if (trigout_ch0 !== 8'h0F || byte_count !== 5'd30) begin n_fail++; $display("FAIL baud_midframe: got ch0=%h count=%0d want 0f/30", trigout_ch0, byte_count); end
    endtask

    task automatic test_wrap();
        baud = 2'b11;
        repeat (2) @(negedge clk);
        send_byte(8'h00, B11, 1'b1, 1);
        n_cmp++; if (byte_count !== 5'd31) begin n_fail++; $display("FAIL count_31: got %0d want 31", byte_count); end
        send_byte(8'h00, B11, 1'b1, 1);
        n_cmp++; if (byte_count !== 5'd0) begin n_fail++; $display("FAIL count_wrap: got %0d want 0", byte_count); end
        n_cmp++; if ({trigout_ch0, trigout_ch1, trigout_ch2, trigout_ch3} !== 32'h0F964D3C) begin n_fail++; $display("FAIL final_regs: got %h want 0f964d3c", {trigout_ch0, trigout_ch1, trigout_ch2, trigout_ch3}); end
        n_cmp++; if (trig_cnt !== 9) begin n_fail++; $display("FAIL total_pulses: got %0d want 9", trig_cnt); end
    endtask

`ifdef UART_ECHO_EN
    task automatic test_echo();
        bit   idle_ok = 1'b0;
        bit   seen = 1'b0;
        int   lowc = 0;
        logic [7:0] got = 8'h00;
        for (int i = 0; i < 20000 && !idle_ok; i++) begin
            @(negedge clk);
            if (busy === 1'b0) idle_ok = 1'b1;
        end
        n_cmp++; if (!idle_ok) begin n_fail++; $display("FAIL echo_drain: got busy=%b want 0", busy); end
        baud = 2'b10;
        repeat (2) @(negedge clk);
        fork
            send_byte(8'h53, B10, 1'b1, 1);
            begin
                for (int i = 0; i < 4000 && !seen; i++) begin
                    @(negedge clk);
                    if (tx === 1'b0) seen = 1'b1;
                end
                while (seen && tx === 1'b0 && lowc < 1000) begin
                    lowc++;
                    @(negedge clk);
                end
                n_cmp++; if (lowc != B10) begin n_fail++; $display("FAIL echo_start_len: got %0d want %0d", lowc, B10); end
                repeat (B10 / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    got[i] = tx;
                    repeat (B10) @(negedge clk);
                end
                n_cmp++; if (got !== 8'h53) begin n_fail++; $display("FAIL echo_data: got %h want 53", got); end
                n_cmp++; if (tx !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL echo_stop: got tx=%b busy=%b want 1/1", tx, busy); end
                repeat (B10 / 2 + 2) @(negedge clk);
                n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL echo_busy_end: got %b want 0", busy); end
            end
        join
        baud = 2'b11;
    endtask
`else
    task automatic test_tx_idle();
        n_cmp++; if (tx_bad != 0) begin n_fail++; $display("FAIL tx_held_high: got %0d non-idle cycles want 0", tx_bad); end
    endtask
`endif

    task automatic test_reset_midframe();
        baud = 2'b11;
        rx = 1'b0;
        repeat (B11) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = i[0];
            repeat (B11) @(negedge clk);
        end
        mon_on = 1'b0;
        nrst = 1'b0;
        rx = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || byte_count !== 5'd0 || vt_ind !== 3'b000) begin n_fail++; $display("FAIL midreset_ctrl: got busy=%b count=%0d vt=%b want 0/0/000", busy, byte_count, vt_ind); end
        n_cmp++; if ({trigout_ch0, trigout_ch1, trigout_ch2, trigout_ch3} !== 32'h0 || tx !== 1'b1) begin n_fail++; $display("FAIL midreset_regs: got %h tx=%b want 0/1", {trigout_ch0, trigout_ch1, trigout_ch2, trigout_ch3}, tx); end
        nrst = 1'b1;
        repeat (12 * B11) @(negedge clk);
        n_cmp++; if (byte_count !== 5'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL midreset_abandon: got count=%0d busy=%b want 0/0", byte_count, busy); end
    endtask

    initial begin
        test_reset();
        test_trigger_ch0();
        test_trigger_ch3();
        test_bad_channel();
        test_framing_error();
        test_glitch();
        test_tolerance();
        test_baud_select();
        test_wrap();
`ifdef UART_ECHO_EN
        test_echo();
`else
        test_tx_idle();
`endif
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_rx_buff_baud3.md
Name: uart_tx_rx_buff_baud3

Overview:
UART receiver/transmitter with a 3-byte command parser that loads four 8-bit trigger-level registers (trigout_ch0..3) from a host serial link. It runs at 12 MHz and supports four baud rates selected by the `baud` input. It sits between the host UART pins and the trigger logic, and provides debug mirrors of the line signals plus status outputs.

Parameters:
- CLK_HZ, 12000000, system clock frequency used to derive the bit divisors.
- DIV_9600, 1250, clocks per bit for baud=2'b11.
- DIV_2400, 5000, clocks per bit for baud=2'b10.
- DIV_600, 20000, clocks per bit for baud=2'b01.
- DIV_110, 109091, clocks per bit for baud=2'b00.

Ports:
- clk  in  1  12 MHz system clock.
- nrst  in  1  reset: synchronous, active-low.
- baud  in  2  rate select: 00=110, 01=600, 10=2400, 11=9600 baud.
- rx  in  1  serial input, idle high, 8N1 framing, LSB first.
- tx  out  1  serial output, idle high, 8N1 framing.
- rx2  out  1  debug mirror of the synchronized rx.
- tx2  out  1  debug mirror of tx.
- trigout_ch0..trigout_ch3  out  8 each  trigger-level registers.
- busy  out  1  high while an rx frame or a tx frame is in progress.
- trig_en  out  1  one-cycle pulse when a trigger register is written.
- vt_ind  out  3  {valid, ch[1:0]} of the last channel written.
- byte_count  out  5  count of good bytes received, wraps 31->0.

Behaviour:
- Reset (nrst=0 at a clk edge) forces: tx=1, tx2=1, rx2=1, trigout_ch0..3=8'h00, busy=0, trig_en=0, vt_ind=0, byte_count=0, all FSMs to IDLE, and both rx synchronizer flops to 1. Reset asserted mid-frame abandons that frame.
- rx path: 2-flop synchronizer; rx2 = synchronized rx.
- Bit divisor N is selected from `baud` and re-sampled only in IDLE. A change of `baud` mid-frame takes effect on the next frame.
- RX FSM, states IDLE/START/DATA/STOP:
  - IDLE: wait for synchronized rx=0.
  - START: wait N/2 clocks, then re-check the line. If rx=1 it was a glitch; return to IDLE.
  - DATA: sample at each subsequent N-clock interval, 8 bits, LSB first.
  - STOP: sample once more. If rx=1, the byte is good: assert a one-cycle rx_valid and increment byte_count. If rx=0, it is a framing error: discard the byte, do not count it, and wait for rx=1 before returning to IDLE.
- Parser, states P_IDLE/P_CH/P_VAL, advanced by good bytes only:
  - P_IDLE: 8'h53 ('S') -> P_CH; any other byte is ignored.
  - P_CH: 8'h30..8'h33 ('0'..'3') latches ch=byte[1:0] -> P_VAL; any other byte -> P_IDLE.
  - P_VAL: any byte writes trigout_ch[ch]. In the same cycle: trig_en=1 for exactly one clock, vt_ind={1'b1,ch}, parser -> P_IDLE.
  - The trigout write and the trig_en pulse occur 1 clk after rx_valid of the value byte.
  - Other channels retain their values.
- TX: 8N1 shifter using the same divisor N: start bit, 8 data bits LSB first, stop bit, each bit exactly N clocks. It is fed from a 4-entry FIFO.
  - FIFO full: the new byte is dropped.
  - Simultaneous push and pop: both occur.
- busy = (RX FSM != IDLE) OR (TX FSM != IDLE) OR (FIFO not empty).
- Bit timing tolerance: ±2% baud error must be received correctly.

Optional Feature:
- Macro UART_ECHO_EN.
- Defined: every good rx byte is pushed into the TX FIFO and echoed on tx.
- Undefined: TX FIFO/shifter is omitted; tx is held at 1 and busy reflects RX only.

Test Plan:
- Reset, baud=11 -> tx=1, all trigout=0, byte_count=0, vt_ind=0, busy=0.
- baud=11, send 0x53,0x30,0xAB at 104.167 us/bit -> trigout_ch0=8'hAB, one trig_en pulse, vt_ind=3'b100, byte_count=3, other channels unchanged.
- Same sequence with 10 bit-times of idle between bytes, then 0x53,0x33,0x5A -> trigout_ch3=8'h5A, vt_ind=3'b111, byte_count=6.
- Send 0x53,0x39,0x11 -> no trigout change, no trig_en; a following 0x53,0x31,0x22 sets trigout_ch1=8'h22.
- Frame with stop bit=0 -> byte_count unchanged, parser state unchanged. A 0.3-bit low glitch on rx -> no byte received.
- With UART_ECHO_EN, baud=10: send 0x53 -> tx emits 0x53 with 5000-clock bits; busy high until the tx stop bit ends.
